regfile_mp_sb: RTL and testbench

//  Parametrised multi-port integer register file with a pending-write scoreboard.

---
 rtl/regfile_mp_sb_if.sv | 36 +++
 rtl/regfile_mp_sb.sv | 101 ++++++++++
 tb/tb_regfile_mp_sb.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for the multi-port register file: read, write, issue and debug ports.
// Parameters must match the attached regfile_mp_sb instance.
interface regfile_mp_sb_if #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRD  = 2
);
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                we0;
    logic                we1;
    logic [AW-1:0]       wa0;
    logic [AW-1:0]       wa1;
    logic [XLEN-1:0]     wd0;
    logic [XLEN-1:0]     wd1;
    logic                iss_en;
    logic [AW-1:0]       iss_rd;
    logic [NREG-1:0]     busy_vec;
    logic [AW-1:0]       debug_addr;
    logic [XLEN-1:0]     debug_data;

    modport master (
        output rd_addr, we0, we1, wa0, wa1, wd0, wd1,
        output iss_en, iss_rd, debug_addr,
        input  rd_data, rd_busy, busy_vec, debug_data
    );

    modport slave (
        input  rd_addr, we0, we1, wa0, wa1, wd0, wd1,
        input  iss_en, iss_rd, debug_addr,
        output rd_data, rd_busy, busy_vec, debug_data
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two write ports and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp_sb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRD  = 2
) (
    input logic            clk,
    input logic            rst,
    regfile_mp_sb_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    logic wr0_ok;
    logic wr1_ok;

    assign wr0_ok = bus.we0 && (bus.wa0 != '0);
    assign wr1_ok = bus.we1 && (bus.wa1 != '0);

    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr0_ok) begin
                regs[bus.wa0] <= bus.wd0;
            end
            if (wr1_ok) begin
                regs[bus.wa1] <= bus.wd1;
            end
        end
    end

    // A new issue outranks a retiring write to the same register.
    always_comb begin
        busy_nxt = busy;
        for (int r = 1; r < NREG; r++) begin
            if ((bus.we0 && bus.wa0 == AW'(r)) ||
                (bus.we1 && bus.wa1 == AW'(r))) begin
                busy_nxt[r] = 1'b0;
            end
            if (bus.iss_en && bus.iss_rd == AW'(r)) begin
                busy_nxt[r] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign bus.busy_vec = busy;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign a = bus.rd_addr[k*AW +: AW];

        always_comb begin
            data = regs[a];
            bsy  = busy[a];
`ifdef REGFILE_BYPASS_EN
            if (wr0_ok && bus.wa0 == a) begin
                data = bus.wd0;
                bsy  = 1'b0;
            end
            if (wr1_ok && bus.wa1 == a) begin
                data = bus.wd1;
                bsy  = 1'b0;
            end
            if (((wr0_ok && bus.wa0 == a) || (wr1_ok && bus.wa1 == a)) &&
                bus.iss_en && bus.iss_rd == a) begin
                bsy = 1'b1;
            end
`endif
            if (a == '0) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign bus.rd_data[k*XLEN +: XLEN] = data;
        assign bus.rd_busy[k]              = bsy;
    end

    assign bus.debug_data = (bus.debug_addr == '0) ? '0 : regs[bus.debug_addr];

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb: default build plus a
// 32-bit, 16-entry, 4-read-port instance.
module tb_regfile_mp_sb;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    regfile_mp_sb_if #(.XLEN(64), .NREG(32), .NRD(2)) a ();
    regfile_mp_sb_if #(.XLEN(32), .NREG(16), .NRD(4)) b ();

    regfile_mp_sb #(.XLEN(64), .NREG(32), .NRD(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a.slave)
    );

    regfile_mp_sb #(.XLEN(32), .NREG(16), .NRD(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a.we0 = 0; a.we1 = 0; a.wa0 = '0; a.wa1 = '0;
        a.wd0 = '0; a.wd1 = '0; a.iss_en = 0; a.iss_rd = '0;
    endtask

    task automatic idle_b();
        b.we0 = 0; b.we1 = 0; b.wa0 = '0; b.wa1 = '0;
        b.wd0 = '0; b.wd1 = '0; b.iss_en = 0; b.iss_rd = '0;
    endtask

    function automatic logic [63:0] rda(input int k);
        return a.rd_data[k*64 +: 64];
    endfunction

    function automatic logic [63:0] rdb(input int k);
        return {32'h0, b.rd_data[k*32 +: 32]};
    endfunction

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        idle_a();
        idle_b();
        a.rd_addr = '0;
        a.debug_addr = '0;
        b.rd_addr = '0;
        b.debug_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: prior contents, then reset
        a.we0 = 1; a.wa0 = 5'd5; a.wd0 = 64'h0123_4567_89AB_CDEF;
        a.we1 = 1; a.wa1 = 5'd6; a.wd1 = 64'h5555;
        a.iss_en = 1; a.iss_rd = 5'd10;
        tick();
        idle_a();
        a.rd_addr = {5'd6, 5'd5};
        #1;
        chk("pre_rst_r5", rda(0), 64'h0123_4567_89AB_CDEF);
        chk("pre_rst_busy", 64'(a.busy_vec), 64'h400);
        rst = 1'b1;
        #1;
        chk("rst_hi_r5", rda(0), 64'h0);
        chk("rst_hi_r6", rda(1), 64'h0);
        chk("rst_hi_busy", 64'(a.busy_vec), 64'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_lo_r5", rda(0), 64'h0);
        chk("rst_lo_busy", 64'(a.busy_vec), 64'h0);
        chk("rst_lo_rdbusy", 64'(a.rd_busy), 64'h0);

        // 2: basic write, reg 0 ignored
        a.we0 = 1; a.wa0 = 5'd5; a.wd0 = 64'hDEAD;
        a.we1 = 1; a.wa1 = 5'd0; a.wd1 = 64'h1;
        tick();
        idle_a();
        a.rd_addr = {5'd0, 5'd5};
        #1;
        chk("wr_r5", rda(0), 64'hDEAD);
        chk("wr_r0", rda(1), 64'h0);

        // 3: collision, port 1 wins
        a.we0 = 1; a.wa0 = 5'd7; a.wd0 = 64'hAA;
        a.we1 = 1; a.wa1 = 5'd7; a.wd1 = 64'hBB;
        tick();
        idle_a();
        a.rd_addr = {5'd5, 5'd7};
        a.debug_addr = 5'd7;
        #1;
        chk("coll_r7", rda(0), 64'hBB);
        chk("coll_dbg", a.debug_data, 64'hBB);

        // 4: scoreboard
        a.iss_en = 1; a.iss_rd = 5'd3;
        a.rd_addr = {5'd0, 5'd3};
        #1;
        chk("iss_no_bypass", 64'(a.rd_busy), 64'h0);
        tick();
        idle_a();
        #1;
        chk("iss_busy_vec", 64'(a.busy_vec), 64'h8);
        chk("iss_rd_busy", 64'(a.rd_busy), 64'h1);
        a.iss_en = 1; a.iss_rd = 5'd3;
        a.we0 = 1; a.wa0 = 5'd3; a.wd0 = 64'h42;
        #1;
        chk("setclr_rd_busy", 64'(a.rd_busy), 64'h1);
        tick();
        idle_a();
        #1;
        chk("setclr_busy_vec", 64'(a.busy_vec), 64'h8);
        chk("setclr_r3", rda(0), 64'h42);
        a.we1 = 1; a.wa1 = 5'd3; a.wd1 = 64'h43;
        tick();
        idle_a();
        #1;
        chk("clr_busy_vec", 64'(a.busy_vec), 64'h0);
        chk("clr_r3", rda(0), 64'h43);
        a.iss_en = 1; a.iss_rd = 5'd0;
        a.we0 = 1; a.wa0 = 5'd12; a.wd0 = 64'h7;
        tick();
        idle_a();
        #1;
        chk("iss_r0_clr_idle", 64'(a.busy_vec), 64'h0);

        // 5: same-cycle read of a write, debug never bypasses
        a.we0 = 1; a.wa0 = 5'd9; a.wd0 = 64'h1234;
        a.rd_addr = {5'd9, 5'd3};
        a.debug_addr = 5'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_rd1", rda(1), 64'h1234);
`else
        chk("byp_rd1", rda(1), 64'h0);
`endif
        chk("byp_dbg", a.debug_data, 64'h0);
        tick();
        idle_a();
        #1;
        chk("post_rd1", rda(1), 64'h1234);
        chk("post_dbg", a.debug_data, 64'h1234);

        // 6: 32-bit, 16-entry, 4-port instance
        b.we0 = 1; b.wa0 = 4'd0; b.wd0 = 32'hFF;
        tick();
        for (int i = 1; i < 16; i += 2) begin
            b.we0 = 1; b.wa0 = 4'(i); b.wd0 = 32'(i * 32'h11);
            b.we1 = (i + 1 < 16);
            b.wa1 = 4'(i + 1);
            b.wd1 = 32'((i + 1) * 32'h11);
            tick();
        end
        idle_b();
        for (int g = 0; g < 4; g++) begin
            b.rd_addr = {4'(4*g+3), 4'(4*g+2), 4'(4*g+1), 4'(4*g)};
            #1;
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("b_r%0d", 4*g+k), rdb(k), 64'((4*g+k) * 'h11));
            end
        end
        chk("b_busy", 64'(b.busy_vec), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
